// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: responder end of a host serial link. Collects command packets
// (CMD, address, optional write data) from a UART receiver, runs one request on the
// internal bus and answers through the UART transmitter with ACK, NAK or read data.
module uart_bus_bridge #(
    parameter int ADDR_BYTES  = 2,
    parameter int DATA_BYTES  = 1,
    parameter int RX_TIMEOUT  = 1000000,
    parameter int BUS_TIMEOUT = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [7:0]              rx_data_i,
    input  logic                    rx_valid_i,
    output logic [7:0]              tx_data_o,
    output logic                    tx_start_o,
    input  logic                    tx_busy_i,
    output logic [8*ADDR_BYTES-1:0] addr_o,
    output logic [8*DATA_BYTES-1:0] wdata_o,
    input  logic [8*DATA_BYTES-1:0] rdata_i,
    output logic                    wr_o,
    output logic                    rd_o,
    input  logic                    ack_i,
    output logic                    busy_o
);

    localparam int AW        = 8 * ADDR_BYTES;
    localparam int DW        = 8 * DATA_BYTES;
    localparam int MAX_BYTES = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
    localparam int BYTE_CW   = $clog2(MAX_BYTES + 1);
    localparam int RX_CW     = $clog2(RX_TIMEOUT + 1);
    localparam int BUS_CW    = $clog2(BUS_TIMEOUT + 1);

    localparam logic [BYTE_CW-1:0] ADDR_LAST  = BYTE_CW'(ADDR_BYTES - 1);
    localparam logic [BYTE_CW-1:0] DATA_LAST  = BYTE_CW'(DATA_BYTES - 1);
    localparam logic [BYTE_CW-1:0] DATA_COUNT = BYTE_CW'(DATA_BYTES);
    localparam logic [RX_CW-1:0]   RX_LAST    = RX_CW'(RX_TIMEOUT - 1);
    localparam logic [BUS_CW-1:0]  BUS_LAST   = BUS_CW'(BUS_TIMEOUT - 1);

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] REPLY_ACK = 8'h06;
    localparam logic [7:0] REPLY_NAK = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_BUS,
        S_SEND,
        S_TXWAIT
    } state_e;

    state_e              state_q, state_d;
    logic                is_write_q, is_write_d;
    logic [BYTE_CW-1:0]  byte_cnt_q, byte_cnt_d;
    logic [RX_CW-1:0]    rx_cnt_q, rx_cnt_d;
    logic [BUS_CW-1:0]   bus_cnt_q, bus_cnt_d;
    logic                req_q, req_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [DW-1:0]       wdata_q, wdata_d;
    logic [DW-1:0]       tx_buf_q, tx_buf_d;
    logic [BYTE_CW-1:0]  tx_left_q, tx_left_d;
    logic                tx_start_q, tx_start_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic [BYTE_CW-1:0]  last_idx;

    // Single-byte replies sit in the top byte of the reply shift register.
    function automatic logic [DW-1:0] reply_word(input logic [7:0] b);
        logic [DW-1:0] w;
        w = '0;
        w[DW-1 -: 8] = b;
        return w;
    endfunction

    // Next-state and datapath decode for the packet / bus / reply sequence.
    always_comb begin
        // NOTE: every _d gets its hold value first, so no branch can infer a latch.
        state_d    = state_q;
        is_write_d = is_write_q;
        byte_cnt_d = byte_cnt_q;
        rx_cnt_d   = rx_cnt_q;
        bus_cnt_d  = bus_cnt_q;
        req_d      = req_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        tx_buf_d   = tx_buf_q;
        tx_left_d  = tx_left_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        last_idx   = (state_q == S_ADDR) ? ADDR_LAST : DATA_LAST;

        case (state_q)
            S_IDLE: begin
                if (rx_valid_i) begin
                    byte_cnt_d = '0;
                    rx_cnt_d   = '0;
                    if (rx_data_i == CMD_WRITE || rx_data_i == CMD_READ) begin
                        is_write_d = (rx_data_i == CMD_WRITE);
                        state_d    = S_ADDR;
                    end else begin
                        tx_buf_d  = reply_word(REPLY_NAK);
                        tx_left_d = BYTE_CW'(1);
                        state_d   = S_SEND;
                    end
                end
            end

            S_ADDR, S_WDATA: begin
                if (rx_valid_i) begin
                    rx_cnt_d = '0;
                    if (state_q == S_ADDR) begin
                        addr_d = AW'({addr_q, rx_data_i});
                    end else begin
                        wdata_d = DW'({wdata_q, rx_data_i});
                    end
                    if (byte_cnt_q == last_idx) begin
                        byte_cnt_d = '0;
                        state_d    = (state_q == S_ADDR && is_write_q) ? S_WDATA : S_BUS;
                    end else begin
                        byte_cnt_d = byte_cnt_q + BYTE_CW'(1);
                    end
                end else if (rx_cnt_q == RX_LAST) begin
                    // Host went quiet mid-packet: drop it without a reply.
                    state_d = S_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q + RX_CW'(1);
                end
            end

            S_BUS: begin
                if (!req_q) begin
                    req_d     = 1'b1;
                    bus_cnt_d = '0;
                end else if (ack_i) begin
                    // An ack on the final allowed clock still wins over the timeout.
                    req_d   = 1'b0;
                    state_d = S_SEND;
                    if (is_write_q) begin
                        tx_buf_d  = reply_word(REPLY_ACK);
                        tx_left_d = BYTE_CW'(1);
                    end else begin
                        tx_buf_d  = rdata_i;
                        tx_left_d = DATA_COUNT;
                    end
                end else if (bus_cnt_q == BUS_LAST) begin
                    req_d     = 1'b0;
                    tx_buf_d  = reply_word(REPLY_NAK);
                    tx_left_d = BYTE_CW'(1);
                    state_d   = S_SEND;
                end else begin
                    bus_cnt_d = bus_cnt_q + BUS_CW'(1);
                end
            end

            S_SEND: begin
                if (!tx_busy_i) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = tx_buf_q[DW-1 -: 8];
                    tx_buf_d   = tx_buf_q << 8;
                    tx_left_d  = tx_left_q - BYTE_CW'(1);
                    state_d    = S_TXWAIT;
                end
            end

            S_TXWAIT: begin
                // tx_busy_i only rises after the start strobe, so skip that first cycle.
                if (!tx_start_q && !tx_busy_i) begin
                    state_d = (tx_left_q != '0) ? S_SEND : S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset clears requests and strobes immediately.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            is_write_q <= 1'b0;
            byte_cnt_q <= '0;
            rx_cnt_q   <= '0;
            bus_cnt_q  <= '0;
            req_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            tx_buf_q   <= '0;
            tx_left_q  <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q    <= state_d;
            is_write_q <= is_write_d;
            byte_cnt_q <= byte_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            bus_cnt_q  <= bus_cnt_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            tx_buf_q   <= tx_buf_d;
            tx_left_q  <= tx_left_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign wr_o       = req_q & is_write_q;
    assign rd_o       = req_q & ~is_write_q;
    assign addr_o     = addr_q;
    assign wdata_o    = wdata_q;
    assign tx_start_o = tx_start_q;
    assign tx_data_o  = tx_data_q;
    assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Bench for uart_bus_bridge: directed packets into two instances (1- and 2-byte data),
// with bus/transmitter responders that pop expected transactions from scoreboards.
module tb_uart_bus_bridge;

    localparam int RX_TO  = 20;
    localparam int BUS_TO = 8;
    localparam int TX_CYC = 6;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          len;   // expected request-high clocks, -1 = not checked
    } bus_t;

    logic        clk_i;
    logic        rst_n_i;
    logic [7:0]  rx_data;
    logic        rx_valid_a, rx_valid_b;
    logic [7:0]  tx_data_a, tx_data_b;
    logic        tx_start_a, tx_start_b;
    logic        tx_busy_a, tx_busy_b;
    logic [15:0] addr_a, addr_b;
    logic [7:0]  wdata_a, rdata_a;
    logic [15:0] wdata_b, rdata_b;
    logic        wr_a, rd_a, ack_a, busy_a;
    logic        wr_b, rd_b, ack_b, busy_b;

    int   n_checks = 0;
    int   n_err    = 0;
    int   ack_delay_a = -1;
    int   ack_delay_b = -1;
    bus_t exp_bus_a[$];
    bus_t exp_bus_b[$];
    logic [7:0] exp_tx_a[$];
    logic [7:0] exp_tx_b[$];

    uart_bus_bridge #(.ADDR_BYTES(2), .DATA_BYTES(1), .RX_TIMEOUT(RX_TO), .BUS_TIMEOUT(BUS_TO)) dut_a (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .rx_data_i(rx_data), .rx_valid_i(rx_valid_a),
        .tx_data_o(tx_data_a), .tx_start_o(tx_start_a), .tx_busy_i(tx_busy_a),
        .addr_o(addr_a), .wdata_o(wdata_a), .rdata_i(rdata_a), .wr_o(wr_a), .rd_o(rd_a),
        .ack_i(ack_a), .busy_o(busy_a)
    );

    uart_bus_bridge #(.ADDR_BYTES(2), .DATA_BYTES(2), .RX_TIMEOUT(RX_TO), .BUS_TIMEOUT(BUS_TO)) dut_b (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .rx_data_i(rx_data), .rx_valid_i(rx_valid_b),
        .tx_data_o(tx_data_b), .tx_start_o(tx_start_b), .tx_busy_i(tx_busy_b),
        .addr_o(addr_b), .wdata_o(wdata_b), .rdata_i(rdata_b), .wr_o(wr_b), .rd_o(rd_b),
        .ack_i(ack_b), .busy_o(busy_b)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: DUT produced an event with nothing expected", name);
    endtask

    // Transmitter model and TX monitor: checks each start strobe against the scoreboard.
    task automatic tx_model(input bit sel);
        logic [7:0] e;
        forever begin
            @(negedge clk_i);
            if (sel ? tx_start_b : tx_start_a) begin
                check(sel ? "B tx_start_while_busy" : "A tx_start_while_busy",
                      sel ? tx_busy_b : tx_busy_a, 0);
                if ((sel ? exp_tx_b.size() : exp_tx_a.size()) == 0) begin
                    unexpected(sel ? "B tx_byte" : "A tx_byte");
                end else begin
                    e = sel ? exp_tx_b.pop_front() : exp_tx_a.pop_front();
                    check(sel ? "B tx_byte" : "A tx_byte", sel ? tx_data_b : tx_data_a, e);
                end
                @(posedge clk_i);
                #1;
                check(sel ? "B tx_start_one_cycle" : "A tx_start_one_cycle",
                      sel ? tx_start_b : tx_start_a, 0);
                if (sel) tx_busy_b = 1'b1; else tx_busy_a = 1'b1;
                repeat (TX_CYC) @(posedge clk_i);
                #1;
                if (sel) tx_busy_b = 1'b0; else tx_busy_a = 1'b0;
            end
        end
    endtask

    // Bus responder and monitor: acks after ack_delay request clocks, checks each request.
    task automatic bus_model(input bit sel);
        bus_t        e;
        int          cyc = 0;
        int          cur_len = -1;
        logic        wr, rd;
        logic [15:0] addr, wdata;
        forever begin
            @(negedge clk_i);
            wr    = sel ? wr_b : wr_a;
            rd    = sel ? rd_b : rd_a;
            addr  = sel ? addr_b : addr_a;
            wdata = sel ? wdata_b : {8'h00, wdata_a};
            if (wr || rd) begin
                if (cyc == 0) begin
                    if ((sel ? exp_bus_b.size() : exp_bus_a.size()) == 0) begin
                        unexpected(sel ? "B bus_request" : "A bus_request");
                        cur_len = -1;
                    end else begin
                        e = sel ? exp_bus_b.pop_front() : exp_bus_a.pop_front();
                        cur_len = e.len;
                        check(sel ? "B bus_op" : "A bus_op", {30'd0, wr, rd}, {30'd0, e.wr, ~e.wr});
                        check(sel ? "B bus_addr" : "A bus_addr", addr, e.addr);
                        if (e.wr) check(sel ? "B bus_wdata" : "A bus_wdata", wdata, e.wdata);
                    end
                end
                if (sel) ack_b = (cyc == ack_delay_b); else ack_a = (cyc == ack_delay_a);
                cyc++;
            end else begin
                if (cyc != 0 && cur_len >= 0)
                    check(sel ? "B bus_req_clocks" : "A bus_req_clocks", cyc, cur_len);
                if (sel) ack_b = 1'b0; else ack_a = 1'b0;
                cyc = 0;
            end
        end
    endtask

    initial tx_model(1'b0);
    initial tx_model(1'b1);
    initial bus_model(1'b0);
    initial bus_model(1'b1);

    task automatic send_byte(input bit sel, input logic [7:0] b);
        @(posedge clk_i);
        #1;
        rx_data = b;
        if (sel) rx_valid_b = 1'b1; else rx_valid_a = 1'b1;
        @(posedge clk_i);
        #1;
        rx_valid_a = 1'b0;
        rx_valid_b = 1'b0;
    endtask

    task automatic push_bus_a(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                              input int len);
        bus_t e;
        e.wr = wr; e.addr = addr; e.wdata = wdata; e.len = len;
        exp_bus_a.push_back(e);
    endtask

    // Wait (bounded) for the bridge to return to IDLE and confirm all expectations were consumed.
    task automatic wait_idle(input bit sel, input string name);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_i);
            if (!(sel ? busy_b : busy_a)) break;
        end
        check({name, " busy_low"}, sel ? busy_b : busy_a, 0);
        check({name, " tx_pending"}, sel ? exp_tx_b.size() : exp_tx_a.size(), 0);
        check({name, " bus_pending"}, sel ? exp_bus_b.size() : exp_bus_a.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_t eb;
        rst_n_i    = 1'b0;
        rx_data    = 8'h00;
        rx_valid_a = 1'b0;
        rx_valid_b = 1'b0;
        tx_busy_a  = 1'b0;
        tx_busy_b  = 1'b0;
        rdata_a    = 8'h00;
        rdata_b    = 16'h0000;
        ack_a      = 1'b0;
        ack_b      = 1'b0;

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_ctrl_a", {tx_start_a, wr_a, rd_a, busy_a}, 0);
        check("rst_data_a", {tx_data_a, addr_a, wdata_a}, 0);
        check("rst_ctrl_b", {tx_start_b, wr_b, rd_b, busy_b}, 0);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("idle_after_release", busy_a, 0);

        // Write 57 12 34 A5, ack 3 clocks after wr_o rises
        ack_delay_a = 3;
        push_bus_a(1'b1, 16'h1234, 16'h00A5, 4);
        exp_tx_a.push_back(8'h06);
        send_byte(0, 8'h57); send_byte(0, 8'h12); send_byte(0, 8'h34); send_byte(0, 8'hA5);
        check("wr_latency_not_yet", wr_a, 0);
        @(posedge clk_i);
        #1;
        check("wr_latency_two_clocks", wr_a, 1);
        wait_idle(0, "write");

        // Read 52 00 10, rdata 0x5C
        ack_delay_a = 0;
        rdata_a = 8'h5C;
        push_bus_a(1'b0, 16'h0010, 16'h0000, 1);
        exp_tx_a.push_back(8'h5C);
        send_byte(0, 8'h52); send_byte(0, 8'h00); send_byte(0, 8'h10);
        wait_idle(0, "read");

        // Bad command, then a valid write
        exp_tx_a.push_back(8'h15);
        send_byte(0, 8'h41);
        wait_idle(0, "bad_cmd");
        ack_delay_a = 1;
        push_bus_a(1'b1, 16'hABCD, 16'h003C, 2);
        exp_tx_a.push_back(8'h06);
        send_byte(0, 8'h57); send_byte(0, 8'hAB); send_byte(0, 8'hCD); send_byte(0, 8'h3C);
        wait_idle(0, "write_after_bad");

        // Bus timeout: no ack, then ack on the last allowed clock
        ack_delay_a = -1;
        push_bus_a(1'b0, 16'h0200, 16'h0000, BUS_TO);
        exp_tx_a.push_back(8'h15);
        send_byte(0, 8'h52); send_byte(0, 8'h02); send_byte(0, 8'h00);
        wait_idle(0, "bus_timeout");
        ack_delay_a = BUS_TO - 1;
        rdata_a = 8'h99;
        push_bus_a(1'b0, 16'h0201, 16'h0000, BUS_TO);
        exp_tx_a.push_back(8'h99);
        send_byte(0, 8'h52); send_byte(0, 8'h02); send_byte(0, 8'h01);
        wait_idle(0, "ack_at_timeout");

        // RX timeout: 57 12 then silence
        send_byte(0, 8'h57); send_byte(0, 8'h12);
        repeat (RX_TO - 4) @(posedge clk_i);
        #1;
        check("rx_timeout_still_waiting", busy_a, 1);
        repeat (8) @(posedge clk_i);
        #1;
        check("rx_timeout_aborted", busy_a, 0);

        // Bytes during BUS and TXWAIT are discarded
        ack_delay_a = 2;
        push_bus_a(1'b1, 16'h0042, 16'h0077, 3);
        exp_tx_a.push_back(8'h06);
        send_byte(0, 8'h57); send_byte(0, 8'h00); send_byte(0, 8'h42); send_byte(0, 8'h77);
        send_byte(0, 8'h52);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (tx_start_a) break;
        end
        check("txwait_start_seen", tx_start_a, 1);
        send_byte(0, 8'h52); send_byte(0, 8'h00); send_byte(0, 8'h10);
        wait_idle(0, "drop_during_txwait");
        repeat (4) @(posedge clk_i);
        #1;
        check("no_second_transaction", busy_a, 0);

        // Reset while wr_o is high
        ack_delay_a = -1;
        push_bus_a(1'b1, 16'h0F0F, 16'h0055, -1);
        send_byte(0, 8'h57); send_byte(0, 8'h0F); send_byte(0, 8'h0F); send_byte(0, 8'h55);
        @(posedge clk_i);
        #1;
        check("wr_high_before_reset", wr_a, 1);
        @(posedge clk_i);
        #2;
        rst_n_i = 1'b0;
        #1;
        check("reset_drops_wr", wr_a, 0);
        check("reset_drops_ctrl", {tx_start_a, busy_a}, 0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        ack_delay_a = 0;
        rdata_a = 8'h3A;
        push_bus_a(1'b0, 16'h0F0F, 16'h0000, 1);
        exp_tx_a.push_back(8'h3A);
        send_byte(0, 8'h52); send_byte(0, 8'h0F); send_byte(0, 8'h0F);
        wait_idle(0, "after_reset");

        // Two-byte read on the wide-data instance: BE then EF
        ack_delay_b = 0;
        rdata_b = 16'hBEEF;
        eb.wr = 1'b0; eb.addr = 16'h1234; eb.wdata = 16'h0000; eb.len = 1;
        exp_bus_b.push_back(eb);
        exp_tx_b.push_back(8'hBE);
        exp_tx_b.push_back(8'hEF);
        send_byte(1, 8'h52); send_byte(1, 8'h12); send_byte(1, 8'h34);
        wait_idle(1, "read_two_bytes");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
